// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : definitions
// Description : Shared types and constants for the fetch stage: run-state
//               enumeration and the program-specific branch-target table.
// Revision    : 1.0 - initial release
// ============================================================================
package definitions;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam int BR_LUT_DEPTH = 32;
    // Native width of the table entries; callers resize to their own PC width.
    localparam int LUT_ADDR_W   = 10;

    // Absolute redirect addresses for the current program image.
    function automatic logic [LUT_ADDR_W-1:0] branch_lut(input logic [4:0] idx);
        logic [LUT_ADDR_W-1:0] addr;
        case (idx)
            5'd0:  addr = 10'h040;
            5'd1:  addr = 10'h080;
            5'd2:  addr = 10'h0C0;
            5'd3:  addr = 10'h120;
            5'd4:  addr = 10'h3FC;
            5'd5:  addr = 10'h010;
            5'd6:  addr = 10'h020;
            5'd7:  addr = 10'h200;
            5'd8:  addr = 10'h1F0;
            5'd9:  addr = 10'h0F8;
            5'd10: addr = 10'h155;
            5'd11: addr = 10'h2AA;
            5'd12: addr = 10'h3FF;
            5'd13: addr = 10'h100;
            5'd14: addr = 10'h180;
            5'd15: addr = 10'h1C0;
            5'd16: addr = 10'h0A0;
            5'd17: addr = 10'h0B4;
            5'd18: addr = 10'h0C8;
            5'd19: addr = 10'h0DC;
            5'd20: addr = 10'h250;
            5'd21: addr = 10'h264;
            5'd22: addr = 10'h278;
            5'd23: addr = 10'h28C;
            5'd24: addr = 10'h300;
            5'd25: addr = 10'h314;
            5'd26: addr = 10'h328;
            5'd27: addr = 10'h33C;
            5'd28: addr = 10'h005;
            5'd29: addr = 10'h00A;
            5'd30: addr = 10'h3F0;
            default: addr = 10'h3E0;
        endcase
        return addr;
    endfunction

endpackage : definitions
`default_nettype wire

// File: rtl/fetch_unit_branch_lut_rom.sv
`default_nettype none
// ============================================================================
// Module      : branch_lut_rom
// Description : Combinational 32-entry branch-target lookup.
//   idx  (in,  5)    : table index, taken from Target[4:0]
//   addr (out, PC_W) : absolute redirect address
// Revision    : 1.0 - initial release
// ============================================================================
module branch_lut_rom
    import definitions::*;
#(
    parameter int PC_W = 10
) (
    input  logic [4:0]      idx,
    output logic [PC_W-1:0] addr
);

    // Table entries are LUT_ADDR_W wide; fit them to this PC width.
    assign addr = PC_W'(branch_lut(idx));

endmodule : branch_lut_rom
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Program counter / fetch stage with IDLE-RUN-DONE run control,
//               table-driven redirects and saturating benchmark counters.
//   CLK, RST (async, active-low)
//   Start, Halt, branch_en, jump_en, Target[8:0], program_done : control in
//   PC[PC_W-1:0]  : registered instruction ROM address
//   Busy / Done   : state RUN / state DONE
//   cycle_count, instr_count [CNT_W-1:0] : saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import definitions::*;
#(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Halt,
    input  logic              branch_en,
    input  logic              jump_en,
    input  logic [8:0]        Target,
    input  logic              program_done,
    output logic [PC_W-1:0]   PC,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    fetch_state_t     state;
    logic [PC_W-1:0]  lut_addr;
    logic [CNT_W-1:0] cycle_inc;
    logic [CNT_W-1:0] instr_inc;
    logic             unused_target;

    // Only the low five selector bits address the table.
    assign unused_target = ^Target[8:5];

    branch_lut_rom #(
        .PC_W (PC_W)
    ) u_branch_lut_rom (
        .idx  (Target[4:0]),
        .addr (lut_addr)
    );

    // Saturating increments: hold at all-ones instead of wrapping.
    assign cycle_inc = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + CNT_W'(1);
    assign instr_inc = (instr_count == {CNT_W{1'b1}}) ? instr_count : instr_count + CNT_W'(1);

    assign Busy = (state == RUN);
    assign Done = (state == DONE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            PC          <= START_ADDR;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    PC <= START_ADDR;
                    if (Start) begin
                        state       <= RUN;
                        cycle_count <= '0;
                        instr_count <= '0;
                    end
                end
                RUN: begin
                    if (Start) begin
                        // Restart cycle is not itself counted.
                        PC          <= START_ADDR;
                        cycle_count <= '0;
                        instr_count <= '0;
                    end else begin
                        cycle_count <= cycle_inc;
                        if (program_done) begin
                            state <= DONE;
                        end else if (jump_en || branch_en) begin
                            // Both redirects share the table, so jump/branch
                            // priority has no visible effect; Halt is ignored.
                            PC          <= lut_addr;
                            instr_count <= instr_inc;
                        end else if (!Halt) begin
                            PC          <= PC + PC_W'(1);
                            instr_count <= instr_inc;
                        end
                    end
                end
                DONE: begin
                    if (Start) begin
                        state       <= RUN;
                        PC          <= START_ADDR;
                        cycle_count <= '0;
                        instr_count <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    PC    <= START_ADDR;
                end
            endcase
        end
    end

endmodule : fetch_unit
`default_nettype wire
